instr_mem_responder: RTL and testbench
======================================

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL have parameter MemWords, default 1024, instruction memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter RspLatency, default 1, cycles from grant to rvalid (legal 1..4).
REQ-003 SHALL have parameter MaxOutstanding, default 2, granted-but-unanswered request limit (legal 1..4).
REQ-004 SHALL have parameter GntStallEn, default 0; when 1, pseudo-random grant stalls are enabled.
REQ-005 SHALL have parameters ErrBase, default 32'hFFFF_F000, and ErrLimit, default 32'hFFFF_FFFF; inclusive byte range that returns a bus error.
REQ-006 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port instr_req_i, input, 1, fetch request from the prefetch buffer.
REQ-009 SHALL have port instr_addr_i, input, 32, fetch byte address.
REQ-010 SHALL have port instr_gnt_o, output, 1, request accepted this cycle.
REQ-011 SHALL have port instr_rvalid_o, output, 1, response valid this cycle.
REQ-012 SHALL have port instr_rdata_o, output, 32, response data.
REQ-013 SHALL have port instr_err_o, output, 1, response carries bus error.
REQ-014 SHALL have ports load_we_i (input, 1), load_addr_i (input, 32), load_wdata_i (input, 32): word preload write port.
REQ-015 SHALL have port outstanding_o, output, 3, current outstanding count.

Function
REQ-016 instr_gnt_o SHALL be combinational: instr_req_i and (outstanding < MaxOutstanding, or a response pops this cycle) and not stall.
REQ-017 stall SHALL be LFSR bit 0 when GntStallEn=1, else 0; 4-bit Fibonacci LFSR, taps x^4+x^3+1, advances every cycle, reset value 4'b1001.
REQ-018 On grant, data and error SHALL be captured that cycle into an in-order response queue, depth MaxOutstanding.
REQ-019 A request granted in cycle t SHALL produce exactly one rvalid in cycle t+RspLatency; responses strictly in grant order.
REQ-020 Word index SHALL be instr_addr_i[2 +: log2(MemWords)].
REQ-021 Error SHALL be set if addr[1:0]!=0, addr >= MemWords*4, or ErrBase <= addr <= ErrLimit; instr_rdata_o SHALL be 0 on error.
REQ-022 instr_rdata_o and instr_err_o SHALL be 0 whenever instr_rvalid_o=0.
REQ-023 load_we_i SHALL write load_wdata_i to word load_addr_i[2 +: log2(MemWords)] at the clock edge; out-of-range load writes are ignored.
REQ-024 A load write and grant to the same word in one cycle SHALL return the pre-write data.
REQ-025 Simultaneous grant and pop SHALL leave outstanding_o unchanged; grant only +1; pop only -1.
REQ-026 instr_gnt_o SHALL be 0 whenever instr_req_i=0; instr_addr_i is ignored without grant.

Reset
REQ-027 While rst_i=1: instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, outstanding_o=0, LFSR=4'b1001.
REQ-028 Reset mid-operation SHALL discard all pending responses; no rvalid SHALL appear for pre-reset grants.
REQ-029 Memory array contents SHALL NOT be reset.

Structure
REQ-030 Package instr_mem_pkg SHALL hold the response-entry typedef (rdata, err, countdown), LFSR seed and tap constants.
REQ-031 The response queue SHALL be sub-module instr_rsp_queue (in-order, per-entry countdown, push/pop/count).

Verification
REQ-032 Preload word 4 = 32'hDEAD_BEEF, RspLatency=1, req addr 32'h10 -> gnt same cycle, next cycle rvalid, rdata 32'hDEAD_BEEF, err 0.
REQ-033 MaxOutstanding=2, RspLatency=3, req held high at 0x0,0x4,0x8 -> first two granted back-to-back, third granted in the cycle the first response pops; outstanding_o never exceeds 2.
REQ-034 Req addr 32'h0000_0002 then 32'hFFFF_F004 -> both respond err=1, rdata=0, in order.
REQ-035 Load write 32'h1234_5678 to word 8 in same cycle as granted read of 32'h20 (old 0) -> response rdata 0; later read returns 32'h1234_5678.
REQ-036 Two grants outstanding, assert rst_i one cycle -> no rvalid afterwards, outstanding_o=0; GntStallEn=1 stall pattern restarts from seed 4'b1001.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction memory responder.
// Holds the response-queue entry layout and the grant-stall LFSR setup.
package instr_mem_pkg;

    localparam int CntW = 3;

    localparam logic [3:0] LfsrSeed = 4'b1001;
    // Taps for x^4 + x^3 + 1 (state bits 3 and 2).
    localparam logic [3:0] LfsrTaps = 4'b1100;

    typedef struct packed {
        logic [31:0]     rdata;
        logic            err;
        logic [CntW-1:0] countdown;
    } rsp_entry_t;

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[2:0], ^(s & LfsrTaps)};
    endfunction

endpackage

// File: rtl/instr_rsp_queue.sv
// In-order response queue; each entry counts down to its response cycle.
// Ports: push_i/push_rdata_i/push_err_i load an entry, pop_o flags the
// head answering this cycle with head_rdata_o/head_err_o, count_o = fill.
module instr_rsp_queue
    import instr_mem_pkg::*;
#(
    parameter int Depth   = 2,
    parameter int Latency = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic [31:0] push_rdata_i,
    input  logic        push_err_i,
    output logic        pop_o,
    output logic [31:0] head_rdata_o,
    output logic        head_err_o,
    output logic [2:0]  count_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    // Entry is stored at the grant edge, so one cycle is already spent.
    localparam logic [CntW-1:0] Reload = CntW'(Latency - 1);

    rsp_entry_t      slot_q [Depth];
    rsp_entry_t      slot_d [Depth];
    rsp_entry_t      head;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0]      count_q, count_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign head         = slot_q[rd_ptr_q];
    // Equal latency for every entry means the head always matures first.
    assign pop_o        = (count_q != 3'd0) && (head.countdown == '0);
    assign head_rdata_o = head.rdata;
    assign head_err_o   = head.err;
    assign count_o      = count_q;

    always_comb begin
        slot_d = slot_q;
        for (int i = 0; i < Depth; i++) begin
            if (slot_q[i].countdown != '0) begin
                slot_d[i].countdown = slot_q[i].countdown - 1'b1;
            end
        end
        if (push_i) begin
            slot_d[wr_ptr_q].rdata     = push_rdata_i;
            slot_d[wr_ptr_q].err       = push_err_i;
            slot_d[wr_ptr_q].countdown = Reload;
        end
        rd_ptr_d = pop_o  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + {2'b00, push_i} - {2'b00, pop_o};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= 3'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: count_q alone decides validity.
    always_ff @(posedge clk_i) begin
        slot_q <= slot_d;
    end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory model answering fetches with fixed latency, in order.
// Ports: instr_req/addr/gnt fetch handshake, instr_rvalid/rdata/err reply,
// load_we/addr/wdata preload port, outstanding_o granted-unanswered count.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int          MemWords       = 1024,
    parameter int          RspLatency     = 1,
    parameter int          MaxOutstanding = 2,
    parameter bit          GntStallEn     = 1'b0,
    parameter logic [31:0] ErrBase        = 32'hFFFF_F000,
    parameter logic [31:0] ErrLimit       = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_wdata_i,
    output logic [2:0]  outstanding_o
);

    localparam int          IdxW     = $clog2(MemWords);
    localparam logic [32:0] MemBytes = 33'(MemWords) * 33'd4;
    localparam logic [31:0] ErrSpan  = ErrLimit - ErrBase;
    localparam logic [2:0]  MaxOut   = 3'(MaxOutstanding);

    logic [31:0]     mem_q [MemWords];
    logic [3:0]      lfsr_q, lfsr_d;
    logic            stall;
    logic            pop;
    logic            room;
    logic [2:0]      count;
    logic [IdxW-1:0] rd_idx, ld_idx;
    logic            rd_err;
    logic            ld_ok;
    logic [31:0]     rd_data;
    logic [31:0]     head_rdata;
    logic            head_err;

    assign lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = GntStallEn ? lfsr_q[0] : 1'b0;

    // Wrapped difference stays within the span only for ErrBase..ErrLimit.
    assign rd_err = (instr_addr_i[1:0] != 2'b00)
                  | ({1'b0, instr_addr_i} >= MemBytes)
                  | ((instr_addr_i - ErrBase) <= ErrSpan);

    assign rd_idx  = instr_addr_i[2 +: IdxW];
    assign rd_data = rd_err ? 32'h0 : mem_q[rd_idx];

    assign ld_idx = load_addr_i[2 +: IdxW];
    assign ld_ok  = load_we_i & ({1'b0, load_addr_i} < MemBytes);

    // Read above sees the old word when a load hits it in the same cycle.
    always_ff @(posedge clk_i) begin
        if (ld_ok) begin
            mem_q[ld_idx] <= load_wdata_i;
        end
    end

    assign room        = (count < MaxOut) | pop;
    assign instr_gnt_o = ~rst_i & instr_req_i & room & ~stall;

    instr_rsp_queue #(
        .Depth   (MaxOutstanding),
        .Latency (RspLatency)
    ) u_rsp_queue (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (instr_gnt_o),
        .push_rdata_i (rd_data),
        .push_err_i   (rd_err),
        .pop_o        (pop),
        .head_rdata_o (head_rdata),
        .head_err_o   (head_err),
        .count_o      (count)
    );

    assign instr_rvalid_o = pop;
    assign instr_rdata_o  = pop ? head_rdata : 32'h0;
    assign instr_err_o    = pop & head_err;
    assign outstanding_o  = count;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized bench for instr_mem_responder across three configurations.
// A queue of expected responses keyed by due cycle is the reference model.
module tb_instr_mem_responder;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req    [NI];
    logic [31:0] addr   [NI];
    logic        gnt    [NI];
    logic        rvalid [NI];
    logic [31:0] rdata  [NI];
    logic        err    [NI];
    logic [2:0]  outst  [NI];
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_wdata;

    always #5 clk = ~clk;

    instr_mem_responder #(
        .RspLatency(1), .MaxOutstanding(2), .GntStallEn(1'b0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(req[0]), .instr_addr_i(addr[0]),
        .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]),
        .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
        .load_we_i(load_we), .load_addr_i(load_addr),
        .load_wdata_i(load_wdata), .outstanding_o(outst[0])
    );

    instr_mem_responder #(
        .RspLatency(3), .MaxOutstanding(2), .GntStallEn(1'b0)
    ) dut1 (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(req[1]), .instr_addr_i(addr[1]),
        .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]),
        .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
        .load_we_i(load_we), .load_addr_i(load_addr),
        .load_wdata_i(load_wdata), .outstanding_o(outst[1])
    );

    instr_mem_responder #(
        .RspLatency(2), .MaxOutstanding(3), .GntStallEn(1'b1)
    ) dut2 (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(req[2]), .instr_addr_i(addr[2]),
        .instr_gnt_o(gnt[2]), .instr_rvalid_o(rvalid[2]),
        .instr_rdata_o(rdata[2]), .instr_err_o(err[2]),
        .load_we_i(load_we), .load_addr_i(load_addr),
        .load_wdata_i(load_wdata), .outstanding_o(outst[2])
    );

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] d;
        logic        e;
    } pend_t;

    pend_t       pq [$];
    logic [31:0] mem_m  [1024];
    logic [3:0]  lfsr_m [NI];
    int          cyc;
    int          checks;
    int          errors;

    logic        obs_gnt [NI];
    logic        obs_rv  [NI];
    logic        obs_err [NI];
    logic [31:0] obs_d   [NI];
    logic [2:0]  obs_out [NI];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 2;
    endfunction

    function automatic int max_of(input int i);
        return (i == 2) ? 3 : 2;
    endfunction

    function automatic bit stall_en_of(input int i);
        return (i == 2);
    endfunction

    function automatic logic exp_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h0000_1000)
            || (a >= 32'hFFFF_F000);
    endfunction

    function automatic logic [3:0] lfsr_step(input logic [3:0] s);
        int v;
        int fb;
        v  = int'(s);
        fb = ((v >> 3) ^ (v >> 2)) & 1;
        return 4'(((v << 1) & 15) | fb);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] w;
        w = 32'($urandom_range(0, 1023)) << 2;
        case ($urandom_range(0, 9))
            0: return $urandom;
            1: return 32'hFFFF_F000 | ($urandom & 32'h0000_0FFF);
            2: return w | 32'($urandom_range(1, 3));
            3: return 32'h0000_1000 + ($urandom & 32'h0000_FFFF);
            default: return w;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            int          idx;
            int          n;
            logic        e_pop;
            logic        e_gnt;
            logic        e_st;
            logic [31:0] e_d;
            logic        e_e;
            pend_t       p;
            idx = -1;
            n   = 0;
            foreach (pq[k]) begin
                if (pq[k].inst == i) begin
                    n++;
                    if (pq[k].due == cyc) idx = k;
                end
            end
            e_pop = !rst && (idx >= 0);
            e_d   = e_pop ? pq[idx].d : 32'h0;
            e_e   = e_pop ? pq[idx].e : 1'b0;
            e_st  = stall_en_of(i) && lfsr_m[i][0];
            e_gnt = !rst && req[i] && (n < max_of(i) || e_pop) && !e_st;
            obs_gnt[i] = gnt[i];
            obs_rv[i]  = rvalid[i];
            obs_d[i]   = rdata[i];
            obs_err[i] = err[i];
            obs_out[i] = outst[i];
            check($sformatf("gnt%0d@%0d", i, cyc), gnt[i], e_gnt);
            check($sformatf("rvalid%0d@%0d", i, cyc), rvalid[i], e_pop);
            check($sformatf("rdata%0d@%0d", i, cyc), rdata[i], e_d);
            check($sformatf("err%0d@%0d", i, cyc), err[i], e_e);
            check($sformatf("outst%0d@%0d", i, cyc), outst[i],
                  rst ? 0 : n);
            if (e_pop) pq.delete(idx);
            if (e_gnt) begin
                p.inst = i;
                p.due  = cyc + lat_of(i);
                p.e    = exp_err(addr[i]);
                p.d    = p.e ? 32'h0 : mem_m[addr[i][11:2]];
                pq.push_back(p);
            end
        end
        if (load_we && load_addr < 32'h0000_1000)
            mem_m[load_addr[11:2]] = load_wdata;
        for (int i = 0; i < NI; i++)
            lfsr_m[i] = rst ? 4'b1001 : lfsr_step(lfsr_m[i]);
        if (rst) pq.delete();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < NI; i++) req[i] = 1'b0;
        load_we = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        logic [7:0] pat;
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        rst     = 1'b1;
        load_we = 1'b0;
        load_addr  = 32'h0;
        load_wdata = 32'h0;
        for (int i = 0; i < NI; i++) begin
            req[i]    = 1'b1;
            addr[i]   = 32'h0;
            lfsr_m[i] = 4'b1001;
        end
        #1;
        for (int k = 0; k < 3; k++) step();
        check("rst_gnt", obs_gnt[0], 0);
        check("rst_rv", obs_rv[0], 0);
        check("rst_out", obs_out[1], 0);

        rst = 1'b0;
        for (int i = 0; i < NI; i++) req[i] = 1'b0;
        for (int w = 0; w < 1024; w++) begin
            load_we    = 1'b1;
            load_addr  = 32'(w) << 2;
            load_wdata = (w == 4) ? 32'hDEAD_BEEF :
                         (w == 8) ? 32'h0 : $urandom;
            step();
        end
        idle(4);

        req[0] = 1'b1; addr[0] = 32'h10;
        step();
        check("d32_gnt", obs_gnt[0], 1);
        req[0] = 1'b0;
        step();
        check("d32_rv", obs_rv[0], 1);
        check("d32_data", obs_d[0], 32'hDEAD_BEEF);
        check("d32_err", obs_err[0], 0);
        idle(2);

        req[1] = 1'b1; addr[1] = 32'h0;
        step();
        check("d33_g0", obs_gnt[1], 1);
        addr[1] = 32'h4;
        step();
        check("d33_g1", obs_gnt[1], 1);
        addr[1] = 32'h8;
        step();
        check("d33_hold", obs_gnt[1], 0);
        check("d33_out2", obs_out[1], 2);
        step();
        check("d33_g2", obs_gnt[1], 1);
        check("d33_pop", obs_rv[1], 1);
        check("d33_out", obs_out[1], 2);
        idle(5);

        req[0] = 1'b1; addr[0] = 32'h0000_0002;
        step();
        addr[0] = 32'hFFFF_F004;
        step();
        check("d34_rv0", obs_rv[0], 1);
        check("d34_e0", obs_err[0], 1);
        check("d34_d0", obs_d[0], 0);
        req[0] = 1'b0;
        step();
        check("d34_rv1", obs_rv[0], 1);
        check("d34_e1", obs_err[0], 1);
        check("d34_d1", obs_d[0], 0);
        idle(2);

        req[0] = 1'b1; addr[0] = 32'h20;
        load_we = 1'b1; load_addr = 32'h20; load_wdata = 32'h1234_5678;
        step();
        check("d35_gnt", obs_gnt[0], 1);
        req[0] = 1'b0; load_we = 1'b0;
        step();
        check("d35_old", obs_d[0], 32'h0);
        req[0] = 1'b1;
        step();
        req[0] = 1'b0;
        step();
        check("d35_new", obs_d[0], 32'h1234_5678);
        idle(2);

        req[1] = 1'b1; addr[1] = 32'h0;
        step();
        addr[1] = 32'h4;
        step();
        check("d36_out", obs_out[1], 1);
        req[1] = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req[2] = 1'b1; addr[2] = 32'h40;
        pat = 8'b0001_0100;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("d36_stall%0d", k), obs_gnt[2], pat[k]);
            check($sformatf("d36_norv%0d", k), obs_rv[1], 0);
            check($sformatf("d36_out%0d", k), obs_out[1], 0);
        end
        idle(4);

        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NI; i++) begin
                req[i]  = ($urandom_range(0, 3) != 0);
                addr[i] = rand_addr();
            end
            load_we = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0)
                load_addr = 32'h0000_1000 + ($urandom & 32'hFF);
            else
                load_addr = 32'($urandom_range(0, 1023)) << 2;
            load_wdata = $urandom;
            step();
        end
        rst = 1'b0;
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
